// File: rtl/lpc_watchdog_bank.sv
// Bank of NUM_CH watchdog timers behind the LPC index/data register decode.
// Each channel has an atomic timeout load, sticky W1C expiry and a timed reset pulse.
module lpc_watchdog_bank #(
    parameter int         NUM_CH      = 4,
    parameter int         CNT_W       = 16,
    parameter int         PRESCALE    = 1024,
    parameter int         PULSE_TICKS = 16,
    parameter logic [7:0] BASE_ADDR   = 8'h20
) (
    input  logic              lclk,
    input  logic              lreset_n,
    input  logic              lpc_en,
    input  logic              device_cs,
    input  logic [7:0]        addr,
    input  logic [7:0]        din,
    input  logic              io_rden,
    input  logic              io_wren,
    output logic [7:0]        dout,
    input  logic              inhibit,
    output logic [NUM_CH-1:0] wdt_rst_n,
    output logic              wdt_irq
);

    localparam int PS_W      = $clog2(PRESCALE);
    localparam int PULSE_LEN = PULSE_TICKS * PRESCALE;
    localparam int PL_W      = $clog2(PULSE_LEN);
    localparam int GLB_OFF   = 4 * NUM_CH;

    logic              rd;
    logic              wr;
    logic [8:0]        off;
    logic              in_bank;
    logic              is_global;
    logic [2:0]        sel_ch;
    logic [1:0]        sel_reg;
    logic              global_kick;
    logic [PS_W-1:0]   presc_reg;
    logic              tick;
    logic [7:0]        dout_reg;
    logic [7:0]        rd_mux;
    logic [NUM_CH-1:0] expired_vec;
    logic [7:0]        ch_rd_data [NUM_CH];

    assign rd = device_cs & lpc_en & io_rden;
    assign wr = device_cs & lpc_en & io_wren;

    // 9-bit subtraction so indices below BASE_ADDR show up as negative (off[8]=1)
    assign off         = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign in_bank     = !off[8] && (off < 9'(GLB_OFF));
    assign is_global   = (off == 9'(GLB_OFF));
    assign sel_ch      = off[4:2];
    assign sel_reg     = off[1:0];
    assign global_kick = wr & is_global & din[7];

    assign tick = (presc_reg == PS_W'(PRESCALE - 1));

    always_ff @(posedge lclk or negedge lreset_n) begin
        if (!lreset_n) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PS_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             en_reg;
            logic             mode_reg;
            logic             expired_reg;
            logic             armed_reg;
            logic             pulse_reg;
            logic [CNT_W-1:0] timeout_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic [7:0]       shadow_reg;
            logic [PL_W-1:0]  pulse_cnt_reg;
            logic             ch_wr;
            logic             ctrl_wr;
            logic             hi_wr;
            logic             kick;
            logic             rearm;
            logic             to_nz;
            logic             fire;
            logic             running;
            logic             count_en;
            logic [15:0]      to_full;
            logic [7:0]       rd_byte;

            assign ch_wr    = wr & in_bank & (sel_ch == 3'(gi));
            assign ctrl_wr  = ch_wr & (sel_reg == 2'd0);
            assign hi_wr    = ch_wr & (sel_reg == 2'd2);
            assign kick     = (ctrl_wr & din[7]) | global_kick;
            assign rearm    = kick | ~en_reg | hi_wr;
            assign to_nz    = (timeout_reg != '0);
            assign fire     = en_reg & armed_reg & to_nz & (cnt_reg >= timeout_reg);
            assign running  = en_reg & ~inhibit & to_nz;
            assign count_en = ~inhibit & tick & en_reg & to_nz & (cnt_reg < timeout_reg);
            assign to_full  = {din, shadow_reg};

            always_ff @(posedge lclk or negedge lreset_n) begin
                if (!lreset_n) begin
                    en_reg        <= 1'b0;
                    mode_reg      <= 1'b0;
                    expired_reg   <= 1'b0;
                    armed_reg     <= 1'b1;
                    pulse_reg     <= 1'b0;
                    timeout_reg   <= '1;
                    cnt_reg       <= '0;
                    shadow_reg    <= '0;
                    pulse_cnt_reg <= '0;
                end else begin
                    if (ctrl_wr) begin
                        en_reg   <= din[0];
                        mode_reg <= din[1];
                    end
                    if (ch_wr && sel_reg == 2'd1) begin
                        shadow_reg <= din;
                    end
                    if (hi_wr) begin
                        timeout_reg <= to_full[CNT_W-1:0];
                    end

                    if (rearm) begin
                        cnt_reg   <= '0;
                        armed_reg <= 1'b1;
                    end else begin
                        if (fire) begin
                            armed_reg <= 1'b0;
                        end
                        if (count_en) begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end

                    // a simultaneous W1C loses against a new expiry
                    if (fire) begin
                        expired_reg <= 1'b1;
                    end else if (ch_wr && sel_reg == 2'd3 && din[0]) begin
                        expired_reg <= 1'b0;
                    end

                    // pulse length counted in lclk cycles so it is exact whatever the prescaler phase
                    if (pulse_reg) begin
                        if (pulse_cnt_reg == PL_W'(PULSE_LEN - 1)) begin
                            pulse_reg <= 1'b0;
                        end
                        pulse_cnt_reg <= pulse_cnt_reg + PL_W'(1);
                    end else if (fire && !mode_reg) begin
                        pulse_reg     <= 1'b1;
                        pulse_cnt_reg <= '0;
                    end
                end
            end

            always_comb begin
                rd_byte = 8'h00;
                case (sel_reg)
                    2'd0: rd_byte = {6'b0, mode_reg, en_reg};
                    2'd1: rd_byte = timeout_reg[7:0];
                    2'd2: rd_byte = 8'(timeout_reg[CNT_W-1:8]);
                    default: rd_byte = {5'b0, pulse_reg, running, expired_reg};
                endcase
            end

            assign wdt_rst_n[gi]   = ~pulse_reg;
            assign expired_vec[gi] = expired_reg;
            assign ch_rd_data[gi]  = rd_byte;
        end
    endgenerate

    always_comb begin
        rd_mux = 8'hff;
        if (in_bank) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel_ch == 3'(i)) begin
                    rd_mux = ch_rd_data[i];
                end
            end
        end else if (is_global) begin
            rd_mux = 8'(expired_vec);
        end
    end

    always_ff @(posedge lclk or negedge lreset_n) begin
        if (!lreset_n) begin
            dout_reg <= 8'hff;
        end else if (rd && !wr) begin
            dout_reg <= rd_mux;
        end
    end

    assign dout    = dout_reg;
    assign wdt_irq = |expired_vec;

endmodule

// File: tb/tb_lpc_watchdog_bank.sv
// Directed bench for lpc_watchdog_bank: register table plus timed expiry/pulse/collision sequences.
module tb_lpc_watchdog_bank;

    logic       lclk      = 1'b0;
    logic       lreset_n  = 1'b0;
    logic       lpc_en    = 1'b0;
    logic       device_cs = 1'b0;
    logic [7:0] addr      = 8'h00;
    logic [7:0] din       = 8'h00;
    logic       io_rden   = 1'b0;
    logic       io_wren   = 1'b0;
    logic       inhibit   = 1'b0;
    logic [7:0] dout;
    logic [3:0] wdt_rst_n;
    logic       wdt_irq;

    lpc_watchdog_bank #(
        .NUM_CH      (4),
        .CNT_W       (16),
        .PRESCALE    (4),
        .PULSE_TICKS (16),
        .BASE_ADDR   (8'h20)
    ) dut (
        .lclk      (lclk),
        .lreset_n  (lreset_n),
        .lpc_en    (lpc_en),
        .device_cs (device_cs),
        .addr      (addr),
        .din       (din),
        .io_rden   (io_rden),
        .io_wren   (io_wren),
        .dout      (dout),
        .inhibit   (inhibit),
        .wdt_rst_n (wdt_rst_n),
        .wdt_irq   (wdt_irq)
    );

    always #5 lclk = ~lclk;

    typedef struct {
        bit         wr;
        logic [7:0] a;
        logic [7:0] d;
    } vec_t;

    vec_t       tbl[$];
    int         checks   = 0;
    int         failures = 0;
    int         pe_cnt   = 0;
    int         fall_cnt [4] = '{default: 0};
    time        fall_t   [4] = '{default: 0};
    time        rise_t   [4] = '{default: 0};
    logic [3:0] prev_rst = 4'hf;

    // edges since reset release; the DUT prescaler equals pe_cnt % 4 at the next edge
    always @(posedge lclk) begin
        if (!lreset_n) pe_cnt <= 0;
        else           pe_cnt <= pe_cnt + 1;
    end

    always @(posedge lclk) begin
        #1;
        for (int c = 0; c < 4; c++) begin
            if (prev_rst[c] && !wdt_rst_n[c]) begin
                fall_cnt[c]++;
                fall_t[c] = $time;
            end
            if (!prev_rst[c] && wdt_rst_n[c]) rise_t[c] = $time;
        end
        prev_rst = wdt_rst_n;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic add_vec(input bit w, input logic [7:0] a, input logic [7:0] d);
        vec_t v;
        v.wr = w;
        v.a  = a;
        v.d  = d;
        tbl.push_back(v);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge lclk);
        device_cs = 1'b1; lpc_en = 1'b1; addr = a; din = d; io_wren = 1'b1;
        @(negedge lclk);
        device_cs = 1'b0; lpc_en = 1'b0; io_wren = 1'b0;
        $display("WR addr=%02h data=%02h", a, d);
    endtask

    task automatic aligned_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge lclk);
        while (pe_cnt % 4 != 3) @(negedge lclk);
        device_cs = 1'b1; lpc_en = 1'b1; addr = a; din = d; io_wren = 1'b1;
        @(negedge lclk);
        device_cs = 1'b0; lpc_en = 1'b0; io_wren = 1'b0;
        $display("WR@tick addr=%02h data=%02h", a, d);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge lclk);
        device_cs = 1'b1; lpc_en = 1'b1; addr = a; io_rden = 1'b1;
        @(negedge lclk);
        device_cs = 1'b0; lpc_en = 1'b0; io_rden = 1'b0;
        d = dout;
        $display("RD addr=%02h data=%02h", a, d);
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        chk(name, d, exp);
    endtask

    task automatic wait_rst(input int c, input logic lvl, input int bound, output int waited);
        waited = 0;
        while (wdt_rst_n[c] !== lvl && waited < bound) begin
            @(negedge lclk);
            waited++;
        end
        chk($sformatf("wait_rst%0d_%0b", c, lvl), 8'(wdt_rst_n[c]), 8'(lvl));
    endtask

    task automatic wait_irq(input int bound, output int waited);
        waited = 0;
        while (wdt_irq !== 1'b1 && waited < bound) begin
            @(negedge lclk);
            waited++;
        end
        chk("wait_irq", 8'(wdt_irq), 8'h01);
    endtask

    initial begin
        int w;

        // reset state while lreset_n is held low
        repeat (3) @(negedge lclk);
        chk("rst_dout", dout, 8'hff);
        chk("rst_wdt_rst_n", 8'(wdt_rst_n), 8'h0f);
        chk("rst_irq", 8'(wdt_irq), 8'h00);
        lreset_n = 1'b1;

        for (int c = 0; c < 4; c++) begin
            add_vec(1'b0, 8'(8'h20 + 4 * c),     8'h00);
            add_vec(1'b0, 8'(8'h20 + 4 * c + 1), 8'hff);
            add_vec(1'b0, 8'(8'h20 + 4 * c + 2), 8'hff);
            add_vec(1'b0, 8'(8'h20 + 4 * c + 3), 8'h00);
        end
        add_vec(1'b0, 8'h30, 8'h00);
        add_vec(1'b0, 8'h31, 8'hff);
        add_vec(1'b0, 8'h1f, 8'hff);
        // atomic load on ch3, CTRL masking, ignored writes
        add_vec(1'b1, 8'h2d, 8'h10);
        add_vec(1'b0, 8'h2d, 8'hff);
        add_vec(1'b0, 8'h2e, 8'hff);
        add_vec(1'b1, 8'h2e, 8'h00);
        add_vec(1'b0, 8'h2d, 8'h10);
        add_vec(1'b0, 8'h2e, 8'h00);
        add_vec(1'b1, 8'h2c, 8'hfe);
        add_vec(1'b0, 8'h2c, 8'h02);
        add_vec(1'b1, 8'h2c, 8'h00);
        add_vec(1'b0, 8'h2c, 8'h00);
        add_vec(1'b1, 8'h31, 8'h55);
        add_vec(1'b0, 8'h31, 8'hff);
        add_vec(1'b1, 8'h2f, 8'h01);
        add_vec(1'b0, 8'h2f, 8'h00);

        foreach (tbl[i]) begin
            if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].d);
            else           read_chk($sformatf("tbl%0d_%02h", i, tbl[i].a), tbl[i].a, tbl[i].d);
        end

        // basic expiry, ch0 mode 0, timeout 5
        bus_write(8'h21, 8'h05);
        bus_write(8'h22, 8'h00);
        bus_write(8'h20, 8'h01);
        wait_rst(0, 1'b0, 100, w);
        chk_rng("ch0_expiry_delay", w, 16, 24);
        bus_write(8'h20, 8'h00);
        read_chk("ch0_status_pulse", 8'h23, 8'h05);
        chk("ch0_irq_pulse", 8'(wdt_irq), 8'h01);
        wait_rst(0, 1'b1, 100, w);
        chk_int("ch0_pulse_len", int'((rise_t[0] - fall_t[0]) / 10), 64);
        read_chk("ch0_status_after", 8'h23, 8'h01);
        chk("ch0_irq_after", 8'(wdt_irq), 8'h01);
        bus_write(8'h23, 8'h01);
        chk("ch0_irq_cleared", 8'(wdt_irq), 8'h00);
        read_chk("ch0_status_cleared", 8'h23, 8'h00);

        // kick and inhibit, ch1
        bus_write(8'h25, 8'h05);
        bus_write(8'h26, 8'h00);
        bus_write(8'h24, 8'h81);
        for (int k = 0; k < 8; k++) begin
            repeat (10) @(negedge lclk);
            bus_write(8'h24, 8'h81);
        end
        read_chk("ch1_status_kicked", 8'h27, 8'h02);
        bus_write(8'h24, 8'h81);
        inhibit = 1'b1;
        repeat (100) @(negedge lclk);
        read_chk("ch1_status_inhibit", 8'h27, 8'h00);
        chk_int("ch1_no_pulse_inhibit", fall_cnt[1], 0);
        inhibit = 1'b0;
        wait_rst(1, 1'b0, 100, w);
        chk_rng("ch1_delay_after_inhibit", w, 16, 24);
        bus_write(8'h24, 8'h00);
        bus_write(8'h27, 8'h01);

        // mode 1, ch2: status and irq only
        bus_write(8'h29, 8'h05);
        bus_write(8'h2a, 8'h00);
        bus_write(8'h28, 8'h03);
        wait_irq(100, w);
        read_chk("ch2_status_mode1", 8'h2b, 8'h03);
        chk_int("ch2_no_pulse", fall_cnt[2], 0);
        bus_write(8'h2b, 8'h01);
        repeat (60) @(negedge lclk);
        chk("ch2_no_refire", 8'(wdt_irq), 8'h00);
        bus_write(8'h28, 8'h83);
        wait_irq(100, w);
        chk_rng("ch2_refire_delay", w, 16, 24);
        chk_int("ch2_no_pulse_2", fall_cnt[2], 0);
        bus_write(8'h2b, 8'h01);
        bus_write(8'h28, 8'h00);

        // TO_HI commit restarts cnt: ch3 timeout 0x0010, mode 1
        bus_write(8'h2c, 8'h03);
        repeat (40) @(negedge lclk);
        bus_write(8'h2e, 8'h00);
        wait_irq(120, w);
        chk_rng("ch3_restart_delay", w, 60, 68);
        bus_write(8'h2f, 8'h01);
        bus_write(8'h2c, 8'h00);

        // kick landing on a tick with cnt = timeout-1, ch0 timeout 2 mode 1
        bus_write(8'h21, 8'h02);
        bus_write(8'h22, 8'h00);
        aligned_write(8'h20, 8'h83);
        for (int k = 0; k < 5; k++) begin
            repeat (4) @(negedge lclk);
            aligned_write(8'h20, 8'h83);
        end
        read_chk("ch0_kick_at_tick_status", 8'h23, 8'h02);
        chk("ch0_kick_at_tick_irq", 8'(wdt_irq), 8'h00);
        repeat (20) @(negedge lclk);
        chk("ch0_expire_after_kicks", 8'(wdt_irq), 8'h01);

        // W1C in the same cycle as expiry: kick at tick edge T, expiry fires at edge T+9
        aligned_write(8'h20, 8'h83);
        repeat (8) @(negedge lclk);
        device_cs = 1'b1; lpc_en = 1'b1; addr = 8'h23; din = 8'h01; io_wren = 1'b1;
        @(negedge lclk);
        device_cs = 1'b0; lpc_en = 1'b0; io_wren = 1'b0;
        $display("WR addr=23 data=01 (coincident with expiry)");
        read_chk("ch0_w1c_vs_set", 8'h23, 8'h03);

        // GLOBAL kick re-arms channels that already expired
        bus_write(8'h28, 8'h03);
        repeat (40) @(negedge lclk);
        bus_write(8'h23, 8'h01);
        bus_write(8'h2b, 8'h01);
        read_chk("global_cleared", 8'h30, 8'h00);
        bus_write(8'h30, 8'h80);
        repeat (40) @(negedge lclk);
        read_chk("global_rearmed", 8'h30, 8'h05);

        // read and write strobes together: write wins, dout holds
        read_chk("pre_collision_read", 8'h2d, 8'h10);
        @(negedge lclk);
        device_cs = 1'b1; lpc_en = 1'b1; addr = 8'h31; din = 8'h00; io_rden = 1'b1; io_wren = 1'b1;
        @(negedge lclk);
        device_cs = 1'b0; lpc_en = 1'b0; io_rden = 1'b0; io_wren = 1'b0;
        $display("RDWR addr=31 data=00 dout=%02h", dout);
        chk("rdwr_dout_hold", dout, 8'h10);

        // reset asserted in the middle of a ch1 pulse
        bus_write(8'h24, 8'h81);
        wait_rst(1, 1'b0, 100, w);
        repeat (10) @(negedge lclk);
        lreset_n = 1'b0;
        #1;
        chk("midpulse_rst_n", 8'(wdt_rst_n), 8'h0f);
        chk("midpulse_irq", 8'(wdt_irq), 8'h00);
        chk("midpulse_dout", dout, 8'hff);
        repeat (2) @(negedge lclk);
        lreset_n = 1'b1;
        read_chk("post_rst_ch1_status", 8'h27, 8'h00);
        read_chk("post_rst_ch1_to_lo", 8'h25, 8'hff);
        read_chk("post_rst_ch0_ctrl", 8'h20, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
